// File: rtl/phone_card_responder.sv
// Card-side responder for the payphone billing link: serial BCD balance read/write with fixed
// access latency. Optional BCD validation of writes and loads when PHONE_CARD_BCD_CHECK_EN is defined.
module phone_card_responder #(
  parameter int unsigned ACCESS_CYCLES = 4,
  parameter logic [11:0] INIT_BALANCE  = 12'h000
) (
  input  logic        clk_1kHz,
  input  logic        clr,
  input  logic        card_present,
  input  logic        read_req,
  input  logic        write_req,
  input  logic        ser_in,
  input  logic        ser_in_valid,
  input  logic        load_en,
  input  logic [11:0] load_money,
  output logic        ser_out,
  output logic        ser_out_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        card_empty,
  output logic [11:0] balance
);

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdShift,
    StRdDone,
    StWrShift,
    StWrWait,
    StWrDone
  } state_e;

  localparam logic [3:0] WaitLast = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] BitLast  = 4'd11;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] shift_q, shift_d;
  logic [11:0] balance_q, balance_d;
  logic        card_empty_q, card_empty_d;
  logic        ser_out_q, ser_out_d;
  logic        ser_out_valid_q, ser_out_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        commit_ok;
  logic        load_ok;
  logic        abort;

`ifdef PHONE_CARD_BCD_CHECK_EN
  function automatic logic bcd_ok(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  assign commit_ok = bcd_ok(shift_q);
  assign load_ok   = bcd_ok(load_money);
`else
  assign commit_ok = 1'b1;
  assign load_ok   = 1'b1;
`endif

  // Card pulled mid-transaction: drop everything without touching the balance.
  assign abort = (state_q != StIdle) && !card_present;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    balance_d       = balance_q;
    card_empty_d    = (balance_q == 12'h000);
    ser_out_d       = 1'b0;
    ser_out_valid_d = 1'b0;
    busy_d          = (state_q != StIdle);
    done_d          = 1'b0;
    err_d           = 1'b0;

    if (abort) begin
      state_d    = StIdle;
      err_d      = 1'b1;
      busy_d     = 1'b0;
      wait_cnt_d = 4'd0;
      bit_cnt_d  = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (write_req && card_present) begin
            state_d   = StWrShift;
            bit_cnt_d = 4'd0;
            shift_d   = 12'h000;
          end else if (read_req && card_present) begin
            state_d    = StRdWait;
            wait_cnt_d = 4'd0;
          end else if (load_en && load_ok) begin
            balance_d = load_money;
          end
        end
        StRdWait: begin
          if (wait_cnt_q == WaitLast) begin
            state_d    = StRdShift;
            shift_d    = balance_q;
            wait_cnt_d = 4'd0;
            bit_cnt_d  = 4'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        StRdShift: begin
          ser_out_d       = shift_q[11];
          ser_out_valid_d = 1'b1;
          shift_d         = {shift_q[10:0], 1'b0};
          if (bit_cnt_q == BitLast) begin
            state_d   = StRdDone;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StRdDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        StWrShift: begin
          if (ser_in_valid) begin
            shift_d = {shift_q[10:0], ser_in};
            if (bit_cnt_q == BitLast) begin
              state_d    = StWrWait;
              bit_cnt_d  = 4'd0;
              wait_cnt_d = 4'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StWrWait: begin
          if (wait_cnt_q == WaitLast) begin
            state_d    = StWrDone;
            wait_cnt_d = 4'd0;
            if (commit_ok) begin
              balance_d = shift_q;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        StWrDone: begin
          // shift_q still holds the written value, so the verdict matches the commit decision.
          if (commit_ok) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1kHz) begin
    if (clr) begin
      state_q         <= StIdle;
      wait_cnt_q      <= 4'd0;
      bit_cnt_q       <= 4'd0;
      shift_q         <= 12'h000;
      balance_q       <= INIT_BALANCE;
      card_empty_q    <= (INIT_BALANCE == 12'h000);
      ser_out_q       <= 1'b0;
      ser_out_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      balance_q       <= balance_d;
      card_empty_q    <= card_empty_d;
      ser_out_q       <= ser_out_d;
      ser_out_valid_q <= ser_out_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign ser_out       = ser_out_q;
  assign ser_out_valid = ser_out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign card_empty    = card_empty_q;
  assign balance       = balance_q;

endmodule

// File: tb/tb_phone_card_responder.sv
// Directed self-checking bench for phone_card_responder: scoreboarded serial reads/writes,
// card removal, request priority, loads and mid-operation reset.
module tb_phone_card_responder;

  localparam int unsigned Acc     = 4;
  localparam logic [11:0] InitBal = 12'h250;
`ifdef PHONE_CARD_BCD_CHECK_EN
  localparam bit BcdCheck = 1'b1;
`else
  localparam bit BcdCheck = 1'b0;
`endif

  logic        clk_1kHz = 1'b0;
  logic        clr;
  logic        card_present;
  logic        read_req;
  logic        write_req;
  logic        ser_in;
  logic        ser_in_valid;
  logic        load_en;
  logic [11:0] load_money;
  logic        ser_out;
  logic        ser_out_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic        card_empty;
  logic [11:0] balance;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] bal_model;
  logic        bit_q[$];
  logic [11:0] bal_q[$];

  phone_card_responder #(
    .ACCESS_CYCLES(Acc),
    .INIT_BALANCE (InitBal)
  ) dut (
    .clk_1kHz     (clk_1kHz),
    .clr          (clr),
    .card_present (card_present),
    .read_req     (read_req),
    .write_req    (write_req),
    .ser_in       (ser_in),
    .ser_in_valid (ser_in_valid),
    .load_en      (load_en),
    .load_money   (load_money),
    .ser_out      (ser_out),
    .ser_out_valid(ser_out_valid),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .card_empty   (card_empty),
    .balance      (balance)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  task automatic tick();
    @(posedge clk_1kHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full read; optionally raise load_en on the accepting edge (request must win).
  task automatic do_read(input bit load_too);
    int   cyc;
    logic exp_bit;
    for (int i = 11; i >= 0; i--) bit_q.push_back(bal_model[i]);
    read_req = 1'b1;
    if (load_too) begin
      load_en    = 1'b1;
      load_money = 12'h999;
    end
    tick();
    read_req = 1'b0;
    load_en  = 1'b0;
    check("rd_bal_hold", 32'(balance), 32'(bal_model));
    tick();
    cyc = 1;
    check("rd_busy_edge1", 32'(busy), 32'd1);
    while (!ser_out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("rd_latency", 32'(cyc), 32'(1 + Acc));
    for (int i = 0; i < 12; i++) begin
      exp_bit = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
      check("rd_valid", 32'(ser_out_valid), 32'd1);
      check("rd_bit", 32'(ser_out), 32'(exp_bit));
      tick();
    end
    check("rd_done", 32'(done), 32'd1);
    check("rd_valid_off", 32'(ser_out_valid), 32'd0);
    check("rd_no_err", 32'(err), 32'd0);
    tick();
    check("rd_done_pulse", 32'(done), 32'd0);
    check("rd_busy_off", 32'(busy), 32'd0);
    check("rd_bal_end", 32'(balance), 32'(bal_model));
  endtask

  // Serial write; exp_ok selects commit+done versus reject+err.
  task automatic do_write(input logic [11:0] value, input bit gap, input bit both, input bit exp_ok);
    logic [11:0] exp_bal;
    bal_q.push_back(exp_ok ? value : bal_model);
    write_req = 1'b1;
    read_req  = both;
    tick();
    write_req = 1'b0;
    read_req  = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      ser_in       = value[i];
      ser_in_valid = 1'b1;
      tick();
      ser_in_valid = 1'b0;
      if (gap && i != 0) tick();
    end
    check("wr_no_read", 32'(ser_out_valid), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    repeat (Acc - 1) tick();
    check("wr_not_early", 32'(balance), 32'(bal_model));
    tick();
    exp_bal = bal_q.pop_front();
    check("wr_commit", 32'(balance), 32'(exp_bal));
    check("wr_done_early", 32'(done), 32'd0);
    bal_model = exp_bal;
    tick();
    check("wr_done", 32'(done), 32'(exp_ok));
    check("wr_err", 32'(err), 32'(!exp_ok));
    check("wr_empty", 32'(card_empty), 32'(bal_model == 12'h000));
    tick();
    check("wr_busy_off", 32'(busy), 32'd0);
    check("wr_pulse_end", 32'(done | err), 32'd0);
  endtask

  initial begin
    clr          = 1'b1;
    card_present = 1'b1;
    read_req     = 1'b0;
    write_req    = 1'b0;
    ser_in       = 1'b0;
    ser_in_valid = 1'b0;
    load_en      = 1'b0;
    load_money   = 12'h000;
    bal_model    = InitBal;
    tick();
    tick();
    clr = 1'b0;
    check("rst_balance", 32'(balance), 32'(InitBal));
    check("rst_empty", 32'(card_empty), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({ser_out, ser_out_valid, done, err}), 32'd0);

    // Basic read of the reset balance.
    do_read(1'b0);

    // Write with one idle cycle between bits, then read it back.
    do_write(12'h187, 1'b1, 1'b0, 1'b1);
    do_read(1'b0);

    // Non-BCD write.
    do_write(12'h1A0, 1'b0, 1'b0, !BcdCheck);

    // Card pulled after 6 write bits.
    write_req = 1'b1;
    tick();
    write_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ser_in       = 1'b1;
      ser_in_valid = 1'b1;
      tick();
    end
    ser_in_valid = 1'b0;
    card_present = 1'b0;
    tick();
    check("abw_err", 32'(err), 32'd1);
    check("abw_done", 32'(done), 32'd0);
    check("abw_busy", 32'(busy), 32'd0);
    check("abw_bal", 32'(balance), 32'(bal_model));
    tick();
    check("abw_err_pulse", 32'(err), 32'd0);

    // Requests ignored with no card.
    read_req  = 1'b1;
    write_req = 1'b1;
    tick();
    tick();
    check("nocard_busy", 32'(busy), 32'd0);
    read_req     = 1'b0;
    write_req    = 1'b0;
    card_present = 1'b1;
    tick();

    // Card pulled during RD_SHIFT.
    begin
      int cyc;
      read_req = 1'b1;
      tick();
      read_req = 1'b0;
      cyc      = 0;
      while (!ser_out_valid && cyc < 40) begin
        tick();
        cyc++;
      end
      check("abr_started", 32'(ser_out_valid), 32'd1);
      tick();
      tick();
      card_present = 1'b0;
      tick();
      check("abr_valid_off", 32'(ser_out_valid), 32'd0);
      check("abr_err", 32'(err), 32'd1);
      check("abr_bal", 32'(balance), 32'(bal_model));
      card_present = 1'b1;
      tick();
      check("abr_idle", 32'({busy, done, err}), 32'd0);
    end

    // Both requests: write path wins.
    do_write(12'h432, 1'b0, 1'b1, 1'b1);

    // Load zero: card_empty follows a cycle later.
    load_en    = 1'b1;
    load_money = 12'h000;
    tick();
    load_en = 1'b0;
    check("ld_bal", 32'(balance), 32'h000);
    check("ld_empty_lag", 32'(card_empty), 32'(bal_model == 12'h000));
    bal_model = 12'h000;
    tick();
    check("ld_empty", 32'(card_empty), 32'd1);

    // Non-BCD load.
    load_en    = 1'b1;
    load_money = 12'h0F5;
    tick();
    load_en = 1'b0;
    if (!BcdCheck) bal_model = 12'h0F5;
    check("ld_bcd", 32'(balance), 32'(bal_model));
    load_en    = 1'b1;
    load_money = 12'h365;
    tick();
    load_en   = 1'b0;
    bal_model = 12'h365;
    check("ld_valid", 32'(balance), 32'h365);

    // Load coinciding with an accepted read is dropped.
    do_read(1'b1);

    // clr during WR_WAIT.
    write_req = 1'b1;
    tick();
    write_req = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      ser_in       = i[0];
      ser_in_valid = 1'b1;
      tick();
    end
    ser_in_valid = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr       = 1'b0;
    bal_model = InitBal;
    check("clr_bal", 32'(balance), 32'(InitBal));
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_empty", 32'(card_empty), 32'd0);
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        seen_done = seen_done | done | err;
      end
      check("clr_no_done", 32'(seen_done), 32'd0);
      check("clr_bal_hold", 32'(balance), 32'(InitBal));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
